warp_fetcher: RTL and testbench

- Per-warp fetch controller in the compute-unit frontend; sequences the instruction-cache/decoder pipeline.
- Tracks each warp's PC and active mask, and round-robin selects one ready warp per cycle to send to the instruction cache.
- Closes the loop on the decoder's feedback (next PC, stop-warp). Each warp has at most one instruction in flight between fetch and decode.

---
 rtl/warp_fetcher.sv | 144 ++++++++++++++
 tb/tb_warp_fetcher.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/warp_fetcher.sv
// Per-warp fetch controller: tracks PC/mask/state of every warp and round-robin
// issues one READY warp per cycle to the instruction cache, closing the loop on decode feedback.
module warp_fetcher #(
   parameter int PcWidth   = 32,
   parameter int NumWarps  = 8,
   parameter int WarpWidth = 32,
   parameter int WidWidth  = NumWarps > 1 ? $clog2(NumWarps) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 init_valid_i,
   input  logic [WidWidth-1:0]  init_warp_id_i,
   input  logic [PcWidth-1:0]   init_pc_i,
   input  logic [WarpWidth-1:0] init_act_mask_i,
   input  logic                 ic_ready_i,
   output logic                 fe_valid_o,
   output logic [PcWidth-1:0]   fe_pc_o,
   output logic [WarpWidth-1:0] fe_act_mask_o,
   output logic [WidWidth-1:0]  fe_warp_id_o,
   input  logic                 dec_decoded_i,
   input  logic                 dec_stop_warp_i,
   input  logic [WidWidth-1:0]  dec_decoded_warp_id_i,
   input  logic [PcWidth-1:0]   dec_decoded_next_pc_i,
   output logic [NumWarps-1:0]  warp_active_o,
   output logic                 all_idle_o
);

   typedef enum logic [1:0] {IDLE, READY, WAITING} warp_state_e;

   // Fetch handshake: a request transfers in any cycle where fe_valid_o && ic_ready_i;
   // once fe_valid_o rises, all fe_* outputs hold until that transfer happens.
   warp_state_e          state_q [NumWarps];
   warp_state_e          state_d [NumWarps];
   logic [PcWidth-1:0]   pc_q    [NumWarps];
   logic [PcWidth-1:0]   pc_d    [NumWarps];
   logic [WarpWidth-1:0] mask_q  [NumWarps];
   logic [WarpWidth-1:0] mask_d  [NumWarps];

   logic [WidWidth-1:0]  rr_ptr_q;
   logic                 lock_q;
   logic [WidWidth-1:0]  lock_id_q;
   logic                 any_ready;
   logic [WidWidth-1:0]  rr_id;
   logic [WidWidth:0]    rr_sum;
   logic [WidWidth-1:0]  grant_id;
   logic                 handshake;

   // Search READY warps starting at the pointer, wrapping at NumWarps (may be non-power-of-two).
   always_comb begin
      any_ready = 1'b0;
      rr_id     = '0;
      rr_sum    = '0;
      for (int i = 0; i < NumWarps; i++) begin
         rr_sum = {1'b0, rr_ptr_q} + (WidWidth+1)'(i);
         if (rr_sum >= (WidWidth+1)'(NumWarps)) rr_sum = rr_sum - (WidWidth+1)'(NumWarps);
         if (!any_ready && state_q[rr_sum[WidWidth-1:0]] == READY) begin
            any_ready = 1'b1;
            rr_id     = rr_sum[WidWidth-1:0];
         end
      end
   end

   assign grant_id      = lock_q ? lock_id_q : rr_id;
   assign fe_valid_o    = any_ready || lock_q;
   assign handshake     = fe_valid_o && ic_ready_i;
   assign fe_warp_id_o  = fe_valid_o ? grant_id : '0;
   assign fe_pc_o       = fe_valid_o ? pc_q[grant_id] : '0;
   assign fe_act_mask_o = fe_valid_o ? mask_q[grant_id] : '0;

   always_comb begin
      for (int w = 0; w < NumWarps; w++) begin
         state_d[w] = state_q[w];
         pc_d[w]    = pc_q[w];
         mask_d[w]  = mask_q[w];
         case (state_q[w])
            IDLE: begin
               if (init_valid_i && init_warp_id_i == WidWidth'(w)) begin
                  state_d[w] = READY;
                  pc_d[w]    = init_pc_i;
                  mask_d[w]  = init_act_mask_i;
               end
            end
            READY: begin
               if (handshake && grant_id == WidWidth'(w)) state_d[w] = WAITING;
            end
            WAITING: begin
               if (dec_decoded_i && dec_decoded_warp_id_i == WidWidth'(w)) begin
                  state_d[w] = dec_stop_warp_i ? IDLE : READY;
                  pc_d[w]    = dec_decoded_next_pc_i;
               end
            end
            default: state_d[w] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int w = 0; w < NumWarps; w++) begin
            state_q[w] <= IDLE;
            pc_q[w]    <= '0;
            mask_q[w]  <= '0;
         end
      end else begin
         for (int w = 0; w < NumWarps; w++) begin
            state_q[w] <= state_d[w];
            pc_q[w]    <= pc_d[w];
            mask_q[w]  <= mask_d[w];
         end
      end
   end

   // A stalled request pins the granted warp so later READY warps cannot disturb fe_*.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q  <= '0;
         lock_q    <= 1'b0;
         lock_id_q <= '0;
      end else if (handshake) begin
         rr_ptr_q <= (grant_id == WidWidth'(NumWarps - 1)) ? '0 : grant_id + 1'b1;
         lock_q   <= 1'b0;
      end else if (fe_valid_o) begin
         lock_q    <= 1'b1;
         lock_id_q <= grant_id;
      end
   end

   always_comb begin
      for (int w = 0; w < NumWarps; w++) warp_active_o[w] = (state_q[w] != IDLE);
   end
   assign all_idle_o = ~|warp_active_o;

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (rst_ni && init_valid_i && int'(init_warp_id_i) < NumWarps)
         assert (state_q[init_warp_id_i] == IDLE)
            else $warning("init of non-idle warp %0d ignored", init_warp_id_i);
      if (rst_ni && dec_decoded_i && int'(dec_decoded_warp_id_i) < NumWarps)
         assert (state_q[dec_decoded_warp_id_i] == WAITING)
            else $warning("decode for non-waiting warp %0d ignored", dec_decoded_warp_id_i);
   end
`endif

endmodule

// File: tb/tb_warp_fetcher.sv
// Table-driven bench for warp_fetcher: per-cycle input/expected-output records plus
// hand-written reset sequences.
module tb_warp_fetcher;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        init_valid_i;
   logic [2:0]  init_warp_id_i;
   logic [31:0] init_pc_i;
   logic [31:0] init_act_mask_i;
   logic        ic_ready_i;
   logic        fe_valid_o;
   logic [31:0] fe_pc_o;
   logic [31:0] fe_act_mask_o;
   logic [2:0]  fe_warp_id_o;
   logic        dec_decoded_i;
   logic        dec_stop_warp_i;
   logic [2:0]  dec_decoded_warp_id_i;
   logic [31:0] dec_decoded_next_pc_i;
   logic [7:0]  warp_active_o;
   logic        all_idle_o;

   int tests = 0;
   int fails = 0;

   warp_fetcher dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .init_valid_i(init_valid_i), .init_warp_id_i(init_warp_id_i),
      .init_pc_i(init_pc_i), .init_act_mask_i(init_act_mask_i),
      .ic_ready_i(ic_ready_i),
      .fe_valid_o(fe_valid_o), .fe_pc_o(fe_pc_o), .fe_act_mask_o(fe_act_mask_o),
      .fe_warp_id_o(fe_warp_id_o),
      .dec_decoded_i(dec_decoded_i), .dec_stop_warp_i(dec_stop_warp_i),
      .dec_decoded_warp_id_i(dec_decoded_warp_id_i),
      .dec_decoded_next_pc_i(dec_decoded_next_pc_i),
      .warp_active_o(warp_active_o), .all_idle_o(all_idle_o)
   );

   // clock/reset
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        iv;
      logic [2:0]  iid;
      logic [31:0] ipc;
      logic [31:0] imask;
      logic        rdy;
      logic        dv;
      logic        ds;
      logic [2:0]  did;
      logic [31:0] dpc;
      logic        ev;
      logic [2:0]  eid;
      logic [31:0] epc;
      logic [31:0] emask;
      logic [7:0]  eact;
      logic        eidle;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic iv, input logic [2:0] iid, input logic [31:0] ipc,
                      input logic [31:0] imask, input logic rdy, input logic dv,
                      input logic ds, input logic [2:0] did, input logic [31:0] dpc,
                      input logic ev, input logic [2:0] eid, input logic [31:0] epc,
                      input logic [31:0] emask, input logic [7:0] eact, input logic eidle);
      vec_t v;
      v.iv = iv; v.iid = iid; v.ipc = ipc; v.imask = imask; v.rdy = rdy;
      v.dv = dv; v.ds = ds; v.did = did; v.dpc = dpc;
      v.ev = ev; v.eid = eid; v.epc = epc; v.emask = emask; v.eact = eact; v.eidle = eidle;
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      init_valid_i = 1'b0; init_warp_id_i = '0; init_pc_i = '0; init_act_mask_i = '0;
      dec_decoded_i = 1'b0; dec_stop_warp_i = 1'b0; dec_decoded_warp_id_i = '0;
      dec_decoded_next_pc_i = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " fe_valid"}, 64'(fe_valid_o), 64'd0);
      check({tag, " fe_pc"}, 64'(fe_pc_o), 64'd0);
      check({tag, " fe_mask"}, 64'(fe_act_mask_o), 64'd0);
      check({tag, " fe_id"}, 64'(fe_warp_id_o), 64'd0);
      check({tag, " active"}, 64'(warp_active_o), 64'd0);
      check({tag, " all_idle"}, 64'(all_idle_o), 64'd1);
   endtask

   initial begin
      // single fetch, decode feedback, stop
      add(1,2,'h10,'hFFFFFFFF, 1, 0,0,0,0,     0,0,0,0,'h00,1);
      add(0,0,0,0,             1, 0,0,0,0,     1,2,'h10,'hFFFFFFFF,'h04,0);
      add(0,0,0,0,             1, 0,0,0,0,     0,0,0,0,'h04,0);
      add(0,0,0,0,             1, 1,0,2,'h11,  0,0,0,0,'h04,0);
      add(0,0,0,0,             1, 0,0,0,0,     1,2,'h11,'hFFFFFFFF,'h04,0);
      add(0,0,0,0,             1, 1,1,2,0,     0,0,0,0,'h04,0);
      add(0,0,0,0,             1, 0,0,0,0,     0,0,0,0,'h00,1);
      // round robin over warps 0,1,3 with immediate decode
      add(1,0,'h100,'h1,       1, 0,0,0,0,     0,0,0,0,'h00,1);
      add(1,1,'h200,'h3,       1, 0,0,0,0,     1,0,'h100,'h1,'h01,0);
      add(1,3,'h300,'h7,       1, 1,0,0,'h104, 1,1,'h200,'h3,'h03,0);
      add(0,0,0,0,             1, 1,0,1,'h204, 1,3,'h300,'h7,'h0B,0);
      add(0,0,0,0,             1, 1,0,3,'h304, 1,0,'h104,'h1,'h0B,0);
      add(0,0,0,0,             1, 1,0,0,'h108, 1,1,'h204,'h3,'h0B,0);
      add(0,0,0,0,             1, 1,0,1,'h208, 1,3,'h304,'h7,'h0B,0);
      add(0,0,0,0,             1, 1,1,3,'h308, 1,0,'h108,'h1,'h0B,0);
      add(0,0,0,0,             1, 1,1,0,0,     1,1,'h208,'h3,'h03,0);
      add(0,0,0,0,             1, 1,1,1,0,     0,0,0,0,'h02,0);
      add(0,0,0,0,             1, 0,0,0,0,     0,0,0,0,'h00,1);
      // stall with warp 1 granted, warp 0 inited mid-stall
      add(1,1,'h80,'hF0,       1, 0,0,0,0,     0,0,0,0,'h00,1);
      add(0,0,0,0,             0, 0,0,0,0,     1,1,'h80,'hF0,'h02,0);
      add(1,0,'h90,'h0F,       0, 0,0,0,0,     1,1,'h80,'hF0,'h02,0);
      add(0,0,0,0,             0, 0,0,0,0,     1,1,'h80,'hF0,'h03,0);
      add(0,0,0,0,             0, 0,0,0,0,     1,1,'h80,'hF0,'h03,0);
      add(0,0,0,0,             0, 0,0,0,0,     1,1,'h80,'hF0,'h03,0);
      add(0,0,0,0,             1, 0,0,0,0,     1,1,'h80,'hF0,'h03,0);
      add(0,0,0,0,             1, 0,0,0,0,     1,0,'h90,'h0F,'h03,0);
      add(0,0,0,0,             1, 1,1,1,0,     0,0,0,0,'h03,0);
      add(0,0,0,0,             1, 1,1,0,0,     0,0,0,0,'h01,0);
      add(0,0,0,0,             1, 0,0,0,0,     0,0,0,0,'h00,1);
      // stop warp 4, then restart it at 0x40
      add(1,4,'h400,'hFF,      1, 0,0,0,0,     0,0,0,0,'h00,1);
      add(0,0,0,0,             1, 0,0,0,0,     1,4,'h400,'hFF,'h10,0);
      add(0,0,0,0,             1, 1,1,4,0,     0,0,0,0,'h10,0);
      add(1,4,'h40,'hAA,       1, 0,0,0,0,     0,0,0,0,'h00,1);
      add(0,0,0,0,             1, 0,0,0,0,     1,4,'h40,'hAA,'h10,0);
      // simultaneous init/handshake/decode, duplicate inits, final stall
      add(1,7,'h700,'h7,       1, 1,1,4,0,     0,0,0,0,'h10,0);
      add(1,6,'h600,'h6,       1, 0,0,0,0,     1,7,'h700,'h7,'h80,0);
      add(1,5,'h500,'h5,       1, 1,0,7,'h71,  1,6,'h600,'h6,'hC0,0);
      add(1,7,'hDEAD,'h0,      1, 0,0,0,0,     1,7,'h71,'h7,'hE0,0);
      add(1,6,'hBEEF,'h0,      1, 0,0,0,0,     1,5,'h500,'h5,'hE0,0);
      add(0,0,0,0,             1, 1,0,6,'h604, 0,0,0,0,'hE0,0);
      add(0,0,0,0,             1, 0,0,0,0,     1,6,'h604,'h6,'hE0,0);
      add(0,0,0,0,             1, 1,0,7,'h72,  0,0,0,0,'hE0,0);
      add(0,0,0,0,             0, 0,0,0,0,     1,7,'h72,'h7,'hE0,0);

      rst_ni = 1'b0;
      ic_ready_i = 1'b1;
      drive_idle();
      #1 check_reset_outputs("in_reset");
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         init_valid_i = vq[i].iv; init_warp_id_i = vq[i].iid;
         init_pc_i = vq[i].ipc; init_act_mask_i = vq[i].imask;
         ic_ready_i = vq[i].rdy;
         dec_decoded_i = vq[i].dv; dec_stop_warp_i = vq[i].ds;
         dec_decoded_warp_id_i = vq[i].did; dec_decoded_next_pc_i = vq[i].dpc;
         #1;
         check($sformatf("v%0d fe_valid", i), 64'(fe_valid_o), 64'(vq[i].ev));
         if (vq[i].ev) begin
            check($sformatf("v%0d fe_id", i), 64'(fe_warp_id_o), 64'(vq[i].eid));
            check($sformatf("v%0d fe_pc", i), 64'(fe_pc_o), 64'(vq[i].epc));
            check($sformatf("v%0d fe_mask", i), 64'(fe_act_mask_o), 64'(vq[i].emask));
         end
         check($sformatf("v%0d active", i), 64'(warp_active_o), 64'(vq[i].eact));
         check($sformatf("v%0d all_idle", i), 64'(all_idle_o), 64'(vq[i].eidle));
         @(negedge clk_i);
      end

      // warp 7 is locked, warps 5/6 WAITING: asynchronous reset mid-operation
      drive_idle();
      ic_ready_i = 1'b0;
      #1;
      check("locked fe_valid", 64'(fe_valid_o), 64'd1);
      check("locked fe_id", 64'(fe_warp_id_o), 64'd7);
      rst_ni = 1'b0;
      #1 check_reset_outputs("async_reset");
      @(negedge clk_i);
      rst_ni = 1'b1;
      ic_ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         #1 check_reset_outputs($sformatf("post_reset%0d", k));
      end
      init_valid_i = 1'b1; init_warp_id_i = 3'd3; init_pc_i = 32'h33; init_act_mask_i = 32'h1;
      @(negedge clk_i);
      drive_idle();
      #1;
      check("restart fe_valid", 64'(fe_valid_o), 64'd1);
      check("restart fe_id", 64'(fe_warp_id_o), 64'd3);
      check("restart fe_pc", 64'(fe_pc_o), 64'h33);
      check("restart fe_mask", 64'(fe_act_mask_o), 64'h1);
      check("restart active", 64'(warp_active_o), 64'h08);
      @(negedge clk_i);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
